// File: rtl/be_block_splitter.sv
// Splits a big-endian block into a stream of byte-reversed 32-bit words, most-significant word first.
// Optional BE_BLOCK_SPLITTER_SKID_EN adds a one-block skid register, so block_ready no longer depends on word_ready.
module be_block_splitter #(
  parameter int NUM_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   block_valid,
  output logic                   block_ready,
  input  logic [32*NUM_WORDS-1:0] block,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [31:0]            word,
  output logic                   word_last,
  output logic                   dbg_busy
);

  localparam int BW = 32 * NUM_WORDS;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a presented word (word, word_last) holds steady until it is taken.
  state_t          state_q, state_n;
  logic [BW-1:0]   hold_q, hold_n;
  logic [IW-1:0]   idx_q, idx_n, idx_inc;
  logic [31:0]     word_n;
  logic            valid_n, last_n;
  logic            accept, consume, load_en;
  logic [BW-1:0]   load_src;

  function automatic logic [31:0] bswap_slice(input logic [BW-1:0] b, input logic [IW-1:0] i);
    logic [31:0] w;
    w = b[32*(NUM_WORDS-1-int'(i)) +: 32];
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

`ifdef BE_BLOCK_SPLITTER_SKID_EN
  logic [BW-1:0] skid_q, skid_n;
  logic          skid_full_q, skid_full_n;
  assign block_ready = rst_n && !skid_full_q;
`else
  assign block_ready = rst_n && ((state_q == IDLE) || (idx_q == LAST && word_ready));
`endif

  assign accept   = block_valid && block_ready;
  assign consume  = word_valid && word_ready;
  assign idx_inc  = idx_q + 1'b1;
  assign dbg_busy = (state_q == DRAIN);

  always_comb begin
    state_n  = state_q;
    hold_n   = hold_q;
    idx_n    = idx_q;
    word_n   = word;
    valid_n  = word_valid;
    last_n   = word_last;
    load_en  = 1'b0;
    load_src = block;
`ifdef BE_BLOCK_SPLITTER_SKID_EN
    skid_n      = skid_q;
    skid_full_n = skid_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) load_en = 1'b1;
      end
      DRAIN: begin
        if (consume && idx_q == LAST) begin
`ifdef BE_BLOCK_SPLITTER_SKID_EN
          if (skid_full_q) begin
            load_en     = 1'b1;
            load_src    = skid_q;
            skid_full_n = 1'b0;
          end else if (accept) begin
            load_en = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end
`else
          if (accept) begin
            load_en = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end
`endif
        end else if (consume) begin
          idx_n  = idx_inc;
          word_n = bswap_slice(hold_q, idx_inc);
          last_n = (idx_inc == LAST);
        end
`ifdef BE_BLOCK_SPLITTER_SKID_EN
        // A block arriving mid-drain parks in the skid unless it can go straight to hold.
        if (accept && !(consume && idx_q == LAST)) begin
          skid_n      = block;
          skid_full_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    if (load_en) begin
      state_n = DRAIN;
      hold_n  = load_src;
      idx_n   = '0;
      word_n  = bswap_slice(load_src, '0);
      valid_n = 1'b1;
      last_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
`ifdef BE_BLOCK_SPLITTER_SKID_EN
      skid_q      <= '0;
      skid_full_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      hold_q     <= hold_n;
      idx_q      <= idx_n;
      word       <= word_n;
      word_valid <= valid_n;
      word_last  <= last_n;
`ifdef BE_BLOCK_SPLITTER_SKID_EN
      skid_q      <= skid_n;
      skid_full_q <= skid_full_n;
`endif
    end
  end

endmodule
